dsm_bridge_driver: RTL and testbench
====================================

DSM_BRIDGE_DRIVER -- requirements
Module: dsm_bridge_driver

Interface
REQ-001 SHALL have parameter DEAD_CYC, default 4: all-gates-off cycles inserted on every state change (range 1..15).
REQ-002 SHALL have parameter MIN_ON, default 2: minimum cycles held in ZERO/POS/NEG before the next change (range 1..15).
REQ-003 SHALL have port clock  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port pwm  in  2  modulator output code: 00 zero, 01 +1, 10 -1, 11 invalid.
REQ-006 SHALL have port fault_i  in  1  external bridge fault.
REQ-007 SHALL have port fault_clr_i  in  1  fault release request.
REQ-008 SHALL have ports hs_a, ls_a, hs_b, ls_b  out  1 each  H-bridge gate drives, registered.
REQ-009 SHALL have port state_o  out  3  current FSM state encoding.
REQ-010 SHALL have port err_invalid  out  1  sticky flag: code 11 seen.
REQ-011 SHALL have port fault_o  out  1  FAULT state indicator.

Function
REQ-012 SHALL register pwm into pwm_q each cycle; code 11 in pwm_q SHALL be treated as 00.
REQ-013 SHALL implement states ZERO, POS, NEG, DEAD, FAULT.
REQ-014 Gate decode SHALL be: ZERO ls_a=ls_b=1; POS hs_a=ls_b=1; NEG hs_b=ls_a=1; DEAD and FAULT all 0; other gates 0. Registered, updated on the same edge as the state.
REQ-015 hs_x and ls_x of one leg SHALL never both be 1 in any cycle.
REQ-016 In ZERO/POS/NEG, the FSM SHALL go to DEAD when target(pwm_q) differs from the current state and the hold counter has expired; else it SHALL stay.
REQ-017 The hold counter SHALL clear on entry to ZERO/POS/NEG and SHALL expire once the state has been occupied MIN_ON cycles; requests before expiry SHALL be deferred, not dropped.
REQ-018 DEAD SHALL last exactly DEAD_CYC cycles, then enter the state given by pwm_q on its final cycle, even if that equals the state left.
REQ-019 Changes of pwm during DEAD SHALL NOT restart the dead counter.
REQ-020 POS<->NEG SHALL pass through a single DEAD interval, not through ZERO.
REQ-021 Latency: pwm change before edge k, with hold expired -> gates off at edge k+1 -> new gates at edge k+1+DEAD_CYC.
REQ-022 err_invalid SHALL set on the edge after pwm_q==11 and hold until reset.
REQ-023 state_o SHALL encode ZERO=0, POS=1, NEG=2, DEAD=3, FAULT=4.

Reset
REQ-024 While reset is high, the block SHALL be in DEAD with the dead counter loaded, all gates 0, pwm_q=00, err_invalid=0, fault_o=0.
REQ-025 After release, the first active gates SHALL appear DEAD_CYC edges later; reset mid-pulse SHALL force all gates 0 at the next edge.

Configuration
REQ-026 Macro DSM_DRV_FAULT_EN SHALL control the fault feature.
REQ-027 With the macro defined: fault_i high at any edge, in any state, SHALL enter FAULT at the next edge (all gates 0, fault_o=1). FAULT SHALL exit to DEAD only when fault_clr_i=1 and fault_i=0 on the same edge. Fault SHALL win over a simultaneous pwm change.
REQ-028 With the macro undefined: ports SHALL remain; fault_i and fault_clr_i SHALL be ignored; fault_o SHALL be tied 0; FAULT SHALL be unreachable.

Structure
REQ-029 Package dsm_pkg SHALL hold the PWM code constants (PWM_ZERO, PWM_POS, PWM_NEG), the driver state enum, and the state_o encoding.
REQ-030 Dead and hold counting SHALL be one sub-module, dsm_dead_timer: load, decrement, expired flag, 4-bit.

Verification
REQ-031 Defaults; after reset, pwm 00->01 before edge 10 -> all gates 0 at edge 11; hs_a=ls_b=1 at edge 15.
REQ-032 POS held, pwm 01->10 -> exactly 4 all-off cycles, then hs_b=ls_a=1; no ZERO state_o in between.
REQ-033 pwm toggles 01,00,01 on consecutive cycles -> each state held >= MIN_ON cycles; final state POS; leg exclusivity assertion never fires.
REQ-034 pwm=11 for 1 cycle while in ZERO -> err_invalid=1 persists; gates stay ZERO.
REQ-035 DSM_DRV_FAULT_EN defined: fault_i pulse in POS -> gates 0 next edge, fault_o=1. fault_clr_i with fault_i=1 -> stays FAULT. fault_clr_i with fault_i=0 -> DEAD for 4 cycles, then pwm_q state.
REQ-036 Reset asserted mid-NEG -> all gates 0 next edge; after release, 4 cycles of DEAD before any gate is 1.

Source files
------------

// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma H-bridge driver: PWM code constants,
// driver state enum (whose values are the state_o encoding), timer width and
// small decode helpers.
package dsm_pkg;

   localparam int unsigned TMR_W = 4;

   localparam logic [1:0] PWM_ZERO = 2'b00;
   localparam logic [1:0] PWM_POS  = 2'b01;
   localparam logic [1:0] PWM_NEG  = 2'b10;
   localparam logic [1:0] PWM_INV  = 2'b11;

   // Enum values double as the state_o encoding.
   typedef enum logic [2:0] {
      ST_ZERO  = 3'd0,
      ST_POS   = 3'd1,
      ST_NEG   = 3'd2,
      ST_DEAD  = 3'd3,
      ST_FAULT = 3'd4
   } drv_state_e;

   // Conducting state requested by a modulator code; the invalid code maps to zero.
   function automatic drv_state_e pwm_target(input logic [1:0] code);
      drv_state_e t;
      case (code)
         PWM_POS: t = ST_POS;
         PWM_NEG: t = ST_NEG;
         default: t = ST_ZERO;
      endcase
      return t;
   endfunction

   // Gate pattern {hs_a, ls_a, hs_b, ls_b} for a state; anything not conducting is all-off.
   function automatic logic [3:0] gate_decode(input drv_state_e st);
      logic [3:0] g;
      case (st)
         ST_ZERO: g = 4'b0101;
         ST_POS:  g = 4'b1001;
         ST_NEG:  g = 4'b0110;
         default: g = 4'b0000;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/dsm_dead_timer.sv
// Shared dead-time / minimum-hold down-counter. Load a value, count down to
// zero and hold there; expired_o is high while the count is zero.
module dsm_dead_timer
   import dsm_pkg::*;
(
   input  logic             clock,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             expired_o
);

   logic [TMR_W-1:0] cnt_q;
   logic [TMR_W-1:0] cnt_d;

   // Next count: load wins, otherwise decrement and saturate at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register; reset is delivered by the owner as a load.
   always_ff @(posedge clock) begin
      cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dsm_bridge_driver.sv
// H-bridge gate driver for a 3-level delta-sigma modulator output. Inserts
// all-off dead time on every change of conducting state and enforces a minimum
// on-time per state. Optional fault latch enabled by DSM_DRV_FAULT_EN; without
// it the fault ports are ignored and fault_o is tied low.
module dsm_bridge_driver
   import dsm_pkg::*;
#(
   parameter int unsigned DEAD_CYC = 4,
   parameter int unsigned MIN_ON   = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] pwm,
   input  logic       fault_i,
   input  logic       fault_clr_i,
   output logic       hs_a,
   output logic       ls_a,
   output logic       hs_b,
   output logic       ls_b,
   output logic [2:0] state_o,
   output logic       err_invalid,
   output logic       fault_o
);

   // Count reloads: the timer expires after DEAD_CYC / MIN_ON occupied cycles.
   localparam logic [TMR_W-1:0] DEAD_LD = TMR_W'(DEAD_CYC - 1);
   localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(MIN_ON - 1);

   drv_state_e       state_q, state_d;
   logic [1:0]       pwm_q, pwm_d;
   logic             err_q, err_d;
   logic [3:0]       gates_q, gates_d;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_expired;
   drv_state_e       target;

   assign target = pwm_target(pwm_q);

   dsm_dead_timer u_timer (
      .clock      (clock),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expired_o  (tmr_expired)
   );

   // Next state, timer control and sticky error; reset forces DEAD with dead time loaded.
   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = DEAD_LD;
      pwm_d    = pwm;
      err_d    = err_q | (pwm_q == PWM_INV);

      case (state_q)
         ST_ZERO, ST_POS, ST_NEG: begin
            // A pending change simply waits here until the hold time has run out.
            if ((target != state_q) && tmr_expired) begin
               state_d  = ST_DEAD;
               tmr_load = 1'b1;
               tmr_val  = DEAD_LD;
            end
         end
         ST_DEAD: begin
            // Leave to whatever pwm_q asks for now, even the state just left.
            if (tmr_expired) begin
               state_d  = target;
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end
         end
         ST_FAULT: begin
`ifdef DSM_DRV_FAULT_EN
            if (fault_clr_i && !fault_i) begin
               state_d  = ST_DEAD;
               tmr_load = 1'b1;
               tmr_val  = DEAD_LD;
            end
`else
            state_d  = ST_DEAD;
            tmr_load = 1'b1;
            tmr_val  = DEAD_LD;
`endif
         end
         default: begin
            state_d  = ST_DEAD;
            tmr_load = 1'b1;
            tmr_val  = DEAD_LD;
         end
      endcase

`ifdef DSM_DRV_FAULT_EN
      // Fault pre-empts any transition decided above.
      if (fault_i) begin
         state_d  = ST_FAULT;
         tmr_load = 1'b0;
      end
`endif

      if (reset) begin
         state_d  = ST_DEAD;
         tmr_load = 1'b1;
         tmr_val  = DEAD_LD;
         pwm_d    = PWM_ZERO;
         err_d    = 1'b0;
      end

      gates_d = gate_decode(state_d);
   end

   // State, input sample, error flag and gate drives all update on the same edge.
   always_ff @(posedge clock) begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      err_q   <= err_d;
      gates_q <= gates_d;
   end

   assign {hs_a, ls_a, hs_b, ls_b} = gates_q;
   assign state_o     = state_q;
   assign err_invalid = err_q;

`ifdef DSM_DRV_FAULT_EN
   assign fault_o = (state_q == ST_FAULT);
`else
   logic unused_fault;
   assign unused_fault = fault_i ^ fault_clr_i;
   assign fault_o      = 1'b0;
`endif

endmodule

// File: tb/tb_dsm_bridge_driver.sv
// Self-checking bench for dsm_bridge_driver: directed scenarios followed by
// randomized traffic, all checked against an occupancy-time reference model.
module tb_dsm_bridge_driver;

   localparam int DC = 4;
   localparam int MO = 2;
`ifdef DSM_DRV_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] pwm;
   logic       fault_i;
   logic       fault_clr_i;
   logic       hs_a, ls_a, hs_b, ls_b;
   logic [2:0] state_o;
   logic       err_invalid;
   logic       fault_o;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: 0 ZERO, 1 POS, 2 NEG, 3 DEAD, 4 FAULT; age = edges since entry.
   int         m_state = 3;
   int         m_age   = 0;
   logic [1:0] m_pwmq  = 2'b00;
   logic       m_err   = 1'b0;

   dsm_bridge_driver #(.DEAD_CYC(DC), .MIN_ON(MO)) dut (
      .clock       (clock),
      .reset       (reset),
      .pwm         (pwm),
      .fault_i     (fault_i),
      .fault_clr_i (fault_clr_i),
      .hs_a        (hs_a),
      .ls_a        (ls_a),
      .hs_b        (hs_b),
      .ls_b        (ls_b),
      .state_o     (state_o),
      .err_invalid (err_invalid),
      .fault_o     (fault_o)
   );

   always #5 clock = ~clock;

   function automatic logic [3:0] exp_gates(input int st);
      case (st)
         0:       return 4'b0101;
         1:       return 4'b1001;
         2:       return 4'b0110;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] gates_now();
      return {hs_a, ls_a, hs_b, ls_b};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic [1:0] p, input logic fi, input logic fc);
      int tgt;
      int occ;
      int nxt;
      if (r) begin
         m_state = 3;
         m_age   = 0;
         m_pwmq  = 2'b00;
         m_err   = 1'b0;
         return;
      end
      tgt = (m_pwmq == 2'b01) ? 1 : (m_pwmq == 2'b10) ? 2 : 0;
      occ = m_age + 1;
      nxt = m_state;
      if (m_state <= 2) begin
         if (tgt != m_state && occ >= MO) nxt = 3;
      end else if (m_state == 3) begin
         if (occ >= DC) nxt = tgt;
      end else begin
         if (fc && !fi) nxt = 3;
      end
      if (FAULT_EN && fi) nxt = 4;
      m_age   = (nxt != m_state) ? 0 : occ;
      m_err   = m_err | (m_pwmq == 2'b11);
      m_pwmq  = p;
      m_state = nxt;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step(reset, pwm, fault_i, fault_clr_i);
      cyc++;
      #1;
      check("state", 32'(state_o), 32'(m_state));
      check("gates", 32'(gates_now()), 32'(exp_gates(m_state)));
      check("err_invalid", 32'(err_invalid), 32'(m_err));
      check("fault_o", 32'(fault_o), 32'(m_state == 4));
      check("leg_excl", 32'({hs_a & ls_a, hs_b & ls_b}), 32'd0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b1; pwm = 2'b00; fault_i = 1'b0; fault_clr_i = 1'b0;

      // Reset state, then power-up sequence with edges counted from release.
      ticks(3);
      check("rst_gates", 32'(gates_now()), 32'd0);
      reset = 1'b0;
      ticks(9);
      pwm = 2'b01;
      ticks(2);
      check("e11_gates_off", 32'(gates_now()), 32'd0);
      check("e11_dead", 32'(state_o), 32'd3);
      ticks(3);
      check("e14_gates_off", 32'(gates_now()), 32'd0);
      tick();
      check("e15_pos_gates", 32'(gates_now()), 32'b1001);

      // POS -> NEG through a single dead interval.
      ticks(3);
      pwm = 2'b10;
      tick();
      check("pn_still_pos", 32'(state_o), 32'd1);
      tick();
      check("pn_dead0", 32'(state_o), 32'd3);
      for (int i = 1; i < DC; i++) begin
         tick();
         check("pn_dead_n", 32'(state_o), 32'd3);
      end
      tick();
      check("pn_neg_gates", 32'(gates_now()), 32'b0110);

      // Rapid toggling 01,00,01 ends in POS.
      ticks(3);
      pwm = 2'b01; tick();
      pwm = 2'b00; tick();
      pwm = 2'b01; ticks(12);
      check("toggle_final", 32'(state_o), 32'd1);

      // One invalid code while in ZERO.
      pwm = 2'b00; ticks(12);
      pwm = 2'b11; tick();
      pwm = 2'b00; ticks(3);
      check("inv_err", 32'(err_invalid), 32'd1);
      check("inv_gates", 32'(gates_now()), 32'b0101);
      ticks(5);
      check("inv_err_sticky", 32'(err_invalid), 32'd1);

      // Fault pulse while in POS.
      pwm = 2'b01; ticks(12);
      fault_i = 1'b1; tick();
      fault_i = 1'b0;
`ifdef DSM_DRV_FAULT_EN
      check("flt_enter", 32'(state_o), 32'd4);
      check("flt_gates", 32'(gates_now()), 32'd0);
      check("flt_o", 32'(fault_o), 32'd1);
`else
      check("flt_ignored", 32'(state_o), 32'd1);
      check("flt_o_tied", 32'(fault_o), 32'd0);
`endif
      ticks(3);
      fault_clr_i = 1'b1; fault_i = 1'b1; tick();
`ifdef DSM_DRV_FAULT_EN
      check("flt_clr_blocked", 32'(state_o), 32'd4);
`endif
      fault_i = 1'b0; tick();
      fault_clr_i = 1'b0;
`ifdef DSM_DRV_FAULT_EN
      check("flt_exit_dead", 32'(state_o), 32'd3);
      ticks(DC - 1);
      check("flt_dead_last", 32'(gates_now()), 32'd0);
      tick();
`endif
      check("flt_back_pos", 32'(gates_now()), 32'b1001);

      // Reset in the middle of NEG.
      pwm = 2'b10; ticks(12);
      check("pre_rst_neg", 32'(state_o), 32'd2);
      reset = 1'b1; tick();
      check("rst_mid_gates", 32'(gates_now()), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < DC - 1; i++) begin
         tick();
         check("rst_dead_gates", 32'(gates_now()), 32'd0);
      end
      tick();
      check("rst_first_gate", 32'(gates_now()), 32'b0110);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(3, 0) == 0) pwm = 2'($urandom_range(3, 0));
         if (pwm == 2'b11 && $urandom_range(3, 0) != 0) pwm = 2'b00;
         fault_i     = ($urandom_range(39, 0) == 0);
         fault_clr_i = ($urandom_range(3, 0) == 0);
         reset       = ($urandom_range(149, 0) == 0);
         tick();
      end
      reset = 1'b0; fault_i = 1'b0; fault_clr_i = 1'b0;
      ticks(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
